// File: rtl/stack_pkg.sv
// Shared types and helpers for the multi-context stack controller.
// op_t names the per-cycle stack operation; ctx_w derives the context index width.
package stack_pkg;

   typedef enum logic [2:0] {
      OP_NOP,
      OP_PUSH,
      OP_POP,
      OP_REPLACE,
      OP_BYPASS
   } op_t;

   // A single context still needs a one-bit index.
   function automatic int ctx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/stack_ctx_state.sv
// Occupancy state of one stack context.
// Ports: clk, arst_n, inc/dec/clr controls, cnt (current count),
// empty_r/full_r (registered flags derived from the next count).
module stack_ctx_state #(
   parameter int DEPTH = 8,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             arst_n,
   input  logic             inc,
   input  logic             dec,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt,
   output logic             empty_r,
   output logic             full_r
);

   logic [CNT_W-1:0] cnt_d, cnt_q;
   logic             empty_d, empty_q;
   logic             full_d, full_q;

   // clr has priority; the controller never asserts inc and dec together.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else if (dec) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
      empty_d = (cnt_d == '0);
      full_d  = (cnt_d == CNT_W'(DEPTH));
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         cnt_q   <= '0;
         empty_q <= 1'b1;
         full_q  <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         empty_q <= empty_d;
         full_q  <= full_d;
      end
   end

   assign cnt     = cnt_q;
   assign empty_r = empty_q;
   assign full_r  = full_q;

endmodule

// File: rtl/stack_cntrl_mc.sv
// Multi-context LIFO controller over one shared single-port read-first memory.
// Ports: clk, arst_n, push/pop/flush/err_clr requests in; memory enables/address,
// bypass, occupancy, per-context empty/full and sticky error flags out.
module stack_cntrl_mc
   import stack_pkg::*;
#(
   parameter int CTX_N = 4,
   parameter int DEPTH = 8,
   localparam int CTX_W  = ctx_w(CTX_N),
   localparam int PTR_W  = $clog2(DEPTH),
   localparam int CNT_W  = $clog2(DEPTH + 1),
   localparam int ADDR_W = CTX_W + PTR_W
) (
   input  logic              clk,
   input  logic              arst_n,
   input  logic [CTX_W-1:0]  i_ctx,
   input  logic              i_push,
   input  logic              i_pop,
   input  logic              i_flush,
   input  logic [CTX_W-1:0]  i_flush_ctx,
   input  logic              i_err_clr,
   output logic              o_mem_wen,
   output logic              o_mem_ren,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic              o_bypass,
   output logic [CNT_W-1:0]  o_count,
   output logic [CTX_N-1:0]  o_empty_r,
   output logic [CTX_N-1:0]  o_full_r,
   output logic              o_err_ovf_r,
   output logic              o_err_unf_r
);

   logic [CNT_W-1:0] cnt_arr [CTX_N];
   logic [CTX_N-1:0] inc, dec, clr;
   logic [CNT_W-1:0] c;
   logic             ctx_ok;
   logic             flush_hit;
   logic             c_empty, c_full;
   logic             set_ovf, set_unf;
   op_t              op;
   logic             err_ovf_d, err_ovf_q;
   logic             err_unf_d, err_unf_q;

   for (genvar g = 0; g < CTX_N; g++) begin : g_ctx
      stack_ctx_state #(
         .DEPTH (DEPTH),
         .CNT_W (CNT_W)
      ) u_ctx (
         .clk     (clk),
         .arst_n  (arst_n),
         .inc     (inc[g]),
         .dec     (dec[g]),
         .clr     (clr[g]),
         .cnt     (cnt_arr[g]),
         .empty_r (o_empty_r[g]),
         .full_r  (o_full_r[g])
      );
   end

   // Select the targeted context; an index beyond CTX_N-1 is ignored.
   always_comb begin
      c      = '0;
      ctx_ok = 1'b0;
      for (int k = 0; k < CTX_N; k++) begin
         if (CTX_W'(k) == i_ctx) begin
            ctx_ok = 1'b1;
            c      = cnt_arr[k];
         end
      end
   end

   assign c_empty   = (c == '0);
   assign c_full    = (c == CNT_W'(DEPTH));
   assign flush_hit = i_flush && (i_flush_ctx == i_ctx);

   // A flush of the same context swallows the whole push/pop request.
   always_comb begin
      op      = OP_NOP;
      set_ovf = 1'b0;
      set_unf = 1'b0;
      if (ctx_ok && !flush_hit) begin
         unique case (1'b1)
            (i_push && i_pop): op = c_empty ? OP_BYPASS : OP_REPLACE;
            (i_push && !i_pop): begin
               if (c_full) set_ovf = 1'b1;
               else        op      = OP_PUSH;
            end
            (i_pop && !i_push): begin
               if (c_empty) set_unf = 1'b1;
               else         op      = OP_POP;
            end
            default: op = OP_NOP;
         endcase
      end
   end

   // Replace reads and writes the top slot; read-first returns old data.
   always_comb begin
      o_mem_wen  = (op == OP_PUSH) || (op == OP_REPLACE);
      o_mem_ren  = (op == OP_POP) || (op == OP_REPLACE);
      o_bypass   = (op == OP_BYPASS);
      o_mem_addr = '0;
      unique case (op)
         OP_PUSH:
            o_mem_addr = {i_ctx, c[PTR_W-1:0]};
         OP_POP, OP_REPLACE:
            o_mem_addr = {i_ctx, c[PTR_W-1:0] - PTR_W'(1)};
         default:
            o_mem_addr = '0;
      endcase
   end

   always_comb begin
      inc = '0;
      dec = '0;
      clr = '0;
      for (int k = 0; k < CTX_N; k++) begin
         if (CTX_W'(k) == i_ctx) begin
            inc[k] = (op == OP_PUSH);
            dec[k] = (op == OP_POP);
         end
         clr[k] = i_flush && (CTX_W'(k) == i_flush_ctx);
      end
   end

   // A new error beats a coincident clear.
   assign err_ovf_d = set_ovf || (err_ovf_q && !i_err_clr);
   assign err_unf_d = set_unf || (err_unf_q && !i_err_clr);

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         err_ovf_q <= 1'b0;
         err_unf_q <= 1'b0;
      end else begin
         err_ovf_q <= err_ovf_d;
         err_unf_q <= err_unf_d;
      end
   end

   assign o_count     = c;
   assign o_err_ovf_r = err_ovf_q;
   assign o_err_unf_r = err_unf_q;

endmodule

// File: tb/tb_stack_cntrl_mc.sv
// Self-checking bench for stack_cntrl_mc (CTX_N=4, DEPTH=8).
// Scoreboard of expected combinational responses plus a per-context count model.
module tb_stack_cntrl_mc;

   localparam int CTX_N = 4;
   localparam int DEPTH = 8;

   typedef struct {
      logic       wen;
      logic       ren;
      logic [4:0] addr;
      logic       byp;
      logic [3:0] cnt;
   } exp_t;

   logic       clk = 1'b0;
   logic       arst_n = 1'b0;
   logic [1:0] i_ctx = '0;
   logic       i_push = 1'b0;
   logic       i_pop = 1'b0;
   logic       i_flush = 1'b0;
   logic [1:0] i_flush_ctx = '0;
   logic       i_err_clr = 1'b0;
   logic       o_mem_wen, o_mem_ren, o_bypass;
   logic [4:0] o_mem_addr;
   logic [3:0] o_count;
   logic [3:0] o_empty_r, o_full_r;
   logic       o_err_ovf_r, o_err_unf_r;

   int   n_cmp = 0;
   int   n_err = 0;
   int   cnt_m [CTX_N];
   bit   ovf_m, unf_m;
   exp_t exp_q [$];

   stack_cntrl_mc #(.CTX_N(CTX_N), .DEPTH(DEPTH)) dut (
      .clk         (clk),
      .arst_n      (arst_n),
      .i_ctx       (i_ctx),
      .i_push      (i_push),
      .i_pop       (i_pop),
      .i_flush     (i_flush),
      .i_flush_ctx (i_flush_ctx),
      .i_err_clr   (i_err_clr),
      .o_mem_wen   (o_mem_wen),
      .o_mem_ren   (o_mem_ren),
      .o_mem_addr  (o_mem_addr),
      .o_bypass    (o_bypass),
      .o_count     (o_count),
      .o_empty_r   (o_empty_r),
      .o_full_r    (o_full_r),
      .o_err_ovf_r (o_err_ovf_r),
      .o_err_unf_r (o_err_unf_r)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [3:0] empty_m();
      logic [3:0] v;
      for (int k = 0; k < CTX_N; k++) v[k] = (cnt_m[k] == 0);
      return v;
   endfunction

   function automatic logic [3:0] full_m();
      logic [3:0] v;
      for (int k = 0; k < CTX_N; k++) v[k] = (cnt_m[k] == DEPTH);
      return v;
   endfunction

   task automatic chk_state(input string tag);
      chk({tag, ".empty"}, 32'(o_empty_r), 32'(empty_m()));
      chk({tag, ".full"}, 32'(o_full_r), 32'(full_m()));
      chk({tag, ".ovf"}, 32'(o_err_ovf_r), 32'(ovf_m));
      chk({tag, ".unf"}, 32'(o_err_unf_r), 32'(unf_m));
   endtask

   task automatic model_reset();
      for (int k = 0; k < CTX_N; k++) cnt_m[k] = 0;
      ovf_m = 0;
      unf_m = 0;
      exp_q.delete();
   endtask

   // One request cycle: drive at negedge, check comb outputs, then state.
   task automatic cyc(input string tag, input int ctx, input bit push,
                      input bit pop, input bit fl, input int fctx,
                      input bit clr);
      exp_t e;
      int   c, nc;
      bit   fh, so, su;
      exp_t g;
      @(negedge clk);
      i_ctx       = 2'(ctx);
      i_push      = push;
      i_pop       = pop;
      i_flush     = fl;
      i_flush_ctx = 2'(fctx);
      i_err_clr   = clr;
      c  = cnt_m[ctx];
      nc = c;
      fh = fl && (fctx == ctx);
      so = 0;
      su = 0;
      e.wen = 0; e.ren = 0; e.byp = 0; e.addr = '0;
      e.cnt = 4'(c);
      if (!fh) begin
         if (push && pop) begin
            if (c == 0) e.byp = 1;
            else begin
               e.wen = 1; e.ren = 1;
               e.addr = 5'(ctx * DEPTH + c - 1);
            end
         end else if (push) begin
            if (c == DEPTH) so = 1;
            else begin
               e.wen = 1; e.addr = 5'(ctx * DEPTH + c); nc = c + 1;
            end
         end else if (pop) begin
            if (c == 0) su = 1;
            else begin
               e.ren = 1; e.addr = 5'(ctx * DEPTH + c - 1); nc = c - 1;
            end
         end
      end
      exp_q.push_back(e);
      #2;
      if (exp_q.size() == 0) begin
         chk({tag, ".queue"}, 32'd0, 32'd1);
      end else begin
         g = exp_q.pop_front();
         chk({tag, ".wen"}, 32'(o_mem_wen), 32'(g.wen));
         chk({tag, ".ren"}, 32'(o_mem_ren), 32'(g.ren));
         chk({tag, ".addr"}, 32'(o_mem_addr), 32'(g.addr));
         chk({tag, ".byp"}, 32'(o_bypass), 32'(g.byp));
         chk({tag, ".cnt"}, 32'(o_count), 32'(g.cnt));
      end
      @(posedge clk);
      cnt_m[ctx] = nc;
      if (fl) cnt_m[fctx] = 0;
      ovf_m = so || (ovf_m && !clr);
      unf_m = su || (unf_m && !clr);
      #1;
      chk_state(tag);
   endtask

   task automatic idle_probe(input string tag, input int ctx);
      @(negedge clk);
      i_ctx = 2'(ctx); i_push = 0; i_pop = 0; i_flush = 0; i_err_clr = 0;
      #1;
      chk({tag, ".cnt"}, 32'(o_count), 32'(cnt_m[ctx]));
   endtask

   initial begin
      model_reset();
      #12;
      // reset state while held
      chk("rst.empty", 32'(o_empty_r), 32'hF);
      chk("rst.full", 32'(o_full_r), 32'h0);
      chk("rst.cnt", 32'(o_count), 32'h0);
      chk("rst.en", 32'({o_mem_wen, o_mem_ren, o_bypass}), 32'h0);
      chk("rst.err", 32'({o_err_ovf_r, o_err_unf_r}), 32'h0);
      arst_n = 1'b1;

      // fill ctx 2, then overflow
      for (int i = 0; i < DEPTH; i++) cyc("fill2", 2, 1, 0, 0, 0, 0);
      chk("fill2.full2", 32'(o_full_r[2]), 32'h1);
      cyc("ovf2", 2, 1, 0, 0, 0, 0);
      chk("ovf2.flag", 32'(o_err_ovf_r), 32'h1);
      idle_probe("ovf2.hold", 2);

      // underflow then clear
      cyc("unf1", 1, 0, 1, 0, 0, 0);
      chk("unf1.flag", 32'(o_err_unf_r), 32'h1);
      cyc("clr", 0, 0, 0, 0, 0, 1);
      chk("clr.flags", 32'({o_err_ovf_r, o_err_unf_r}), 32'h0);
      // clear coinciding with a new error: set wins
      cyc("clrset", 1, 0, 1, 0, 0, 1);

      // replace on ctx 0 with count 3, bypass on empty ctx 3
      for (int i = 0; i < 3; i++) cyc("fill0", 0, 1, 0, 0, 0, 0);
      cyc("repl0", 0, 1, 1, 0, 0, 0);
      cyc("repl2full", 2, 1, 1, 0, 0, 0);
      cyc("byp3", 3, 1, 1, 0, 0, 0);
      cyc("pop0", 0, 0, 1, 0, 0, 1);

      // flush arbitration
      cyc("fl_same", 2, 1, 0, 1, 2, 0);
      chk("fl_same.empty2", 32'(o_empty_r[2]), 32'h1);
      cyc("fill1", 1, 1, 0, 0, 0, 0);
      cyc("fl_diff", 0, 1, 0, 1, 1, 0);
      cyc("fl_pop_same", 0, 0, 1, 1, 0, 0);
      cyc("fl_empty_pop", 3, 0, 1, 1, 3, 0);

      // async reset mid-sequence
      for (int i = 0; i < 5; i++) cyc("fill1b", 1, 1, 0, 0, 0, 0);
      cyc("unf3", 3, 0, 1, 0, 0, 0);
      @(negedge clk);
      i_ctx = 2'd1; i_push = 0; i_pop = 0; i_flush = 0; i_err_clr = 0;
      #2;
      chk("pre_ar.cnt", 32'(o_count), 32'h5);
      arst_n = 1'b0;
      #1;
      chk("ar.cnt", 32'(o_count), 32'h0);
      chk("ar.empty", 32'(o_empty_r), 32'hF);
      chk("ar.err", 32'({o_err_ovf_r, o_err_unf_r}), 32'h0);
      model_reset();
      @(negedge clk);
      arst_n = 1'b1;

      // random traffic against the model
      for (int i = 0; i < 400; i++) begin
         int r;
         r = int'($urandom_range(0, 9));
         cyc("rnd", int'($urandom_range(0, 3)), r < 6, (r >= 4) && (r < 9),
             ($urandom_range(0, 15) == 0), int'($urandom_range(0, 3)),
             ($urandom_range(0, 7) == 0));
      end

      if (exp_q.size() != 0) chk("end.queue", 32'(exp_q.size()), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
